divider: RTL

Iterative 32-bit radix-2 restoring divider for the EX stage, complementing the combinational multiplier. It accepts a dividend/divisor pair under a level-held enable, runs one quotient bit per cycle, and returns quotient and remainder on a `DOUBLE_DATA_BUS` result. The EX stage stalls the pipeline on `div_en && !done`.

---
 rtl/divider_pkg.sv | 26 ++
 rtl/divider_div_step.sv | 21 ++
 rtl/divider.sv | 119 +++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared widths, FSM state encoding and sign helper for the iterative divider.
package divider_pkg;

  localparam int DATA_BUS_WIDTH        = 32;
  localparam int DOUBLE_DATA_BUS_WIDTH = 2 * DATA_BUS_WIDTH;
  localparam int CNT_WIDTH             = 6;

  localparam logic [DATA_BUS_WIDTH-1:0] SIGNED_MIN = {1'b1, {(DATA_BUS_WIDTH-1){1'b0}}};
  localparam logic [DATA_BUS_WIDTH-1:0] ALL_ONES   = {DATA_BUS_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]      LAST_ITER  = CNT_WIDTH'(DATA_BUS_WIDTH - 1);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_DIV  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

  function automatic logic [DATA_BUS_WIDTH-1:0] neg_if(
    input logic [DATA_BUS_WIDTH-1:0] x,
    input logic                      en
  );
    return en ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and try to subtract the divisor.
module div_step
  import divider_pkg::*;
(
  input  logic [DATA_BUS_WIDTH:0]   i_rem,
  input  logic                      i_dvd_msb,
  input  logic [DATA_BUS_WIDTH-1:0] i_dvs,
  output logic [DATA_BUS_WIDTH:0]   o_rem,
  output logic                      o_q_bit
);

  logic [DATA_BUS_WIDTH:0]   w_shifted;
  logic [DATA_BUS_WIDTH+1:0] w_trial;

  // One extra bit on the subtraction so the borrow is visible as a sign bit.
  assign w_shifted = {i_rem[DATA_BUS_WIDTH-1:0], i_dvd_msb};
  assign w_trial   = {1'b0, w_shifted} - {2'b00, i_dvs};
  assign o_q_bit   = ~w_trial[DATA_BUS_WIDTH+1];
  assign o_rem     = o_q_bit ? w_trial[DATA_BUS_WIDTH:0] : w_shifted;

endmodule

// File: rtl/divider.sv
// Iterative 32-bit restoring divider: one quotient bit per cycle, {remainder, quotient} result.
module divider
  import divider_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             div_en,
  input  logic                             div_signed,
  input  logic                             cancel,
  input  logic [DATA_BUS_WIDTH-1:0]        op1,
  input  logic [DATA_BUS_WIDTH-1:0]        op2,
  output logic                             done,
  output logic [DOUBLE_DATA_BUS_WIDTH-1:0] result_div
);

  div_state_t                       r_state;
  logic [DATA_BUS_WIDTH:0]          r_rem;
  logic [DATA_BUS_WIDTH-1:0]        r_dvd;
  logic [DATA_BUS_WIDTH-1:0]        r_dvs;
  logic [DATA_BUS_WIDTH-1:0]        r_op1;
  logic [DATA_BUS_WIDTH-1:0]        r_op2;
  logic [CNT_WIDTH-1:0]             r_cnt;
  logic                             r_signed;
  logic                             r_q_neg;
  logic                             r_r_neg;
  logic                             r_done;
  logic [DOUBLE_DATA_BUS_WIDTH-1:0] r_result;

  logic [DATA_BUS_WIDTH:0]          w_rem_next;
  logic                             w_q_bit;
  logic [DATA_BUS_WIDTH-1:0]        w_quo;
  logic [DATA_BUS_WIDTH-1:0]        w_rmd;
  logic [DOUBLE_DATA_BUS_WIDTH-1:0] w_fix_result;

  div_step u_div_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[DATA_BUS_WIDTH-1]),
    .i_dvs     (r_dvs),
    .o_rem     (w_rem_next),
    .o_q_bit   (w_q_bit)
  );

  // r_dvd doubles as the quotient register: dividend bits shift out the top, quotient bits in the bottom.
  always_comb begin
    w_quo = neg_if(r_dvd, r_q_neg);
    w_rmd = neg_if(r_rem[DATA_BUS_WIDTH-1:0], r_r_neg);
    if (r_op2 == '0) begin
      w_fix_result = {r_op1, ALL_ONES};
    end else if (r_signed && (r_op1 == SIGNED_MIN) && (r_op2 == ALL_ONES)) begin
      w_fix_result = {{DATA_BUS_WIDTH{1'b0}}, SIGNED_MIN};
    end else begin
      w_fix_result = {w_rmd, w_quo};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DIV_IDLE;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (cancel) begin
      r_state <= DIV_IDLE;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        DIV_IDLE: begin
          if (div_en) begin
            r_op1    <= op1;
            r_op2    <= op2;
            r_signed <= div_signed;
            r_dvd    <= neg_if(op1, div_signed & op1[DATA_BUS_WIDTH-1]);
            r_dvs    <= neg_if(op2, div_signed & op2[DATA_BUS_WIDTH-1]);
            r_q_neg  <= div_signed & (op1[DATA_BUS_WIDTH-1] ^ op2[DATA_BUS_WIDTH-1]);
            r_r_neg  <= div_signed & op1[DATA_BUS_WIDTH-1];
            r_rem    <= '0;
            r_cnt    <= '0;
            r_state  <= DIV_DIV;
          end
        end
        DIV_DIV: begin
          r_rem <= w_rem_next;
          r_dvd <= {r_dvd[DATA_BUS_WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          r_result <= w_fix_result;
          r_done   <= 1'b1;
          r_state  <= DIV_DONE;
        end
        DIV_DONE: begin
          if (!div_en) begin
            r_done  <= 1'b0;
            r_state <= DIV_IDLE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= DIV_IDLE;
        end
      endcase
    end
  end

  assign done       = r_done;
  assign result_div = r_result;

endmodule
